// File: rtl/isqrt_pkg.sv
// Shared widths and pipeline-stage record for the integer square-root block.
// The formula tops import the widths from here as well.
package isqrt_pkg;

  localparam int ISQRT_X_W = 32;
  localparam int ISQRT_Y_W = 16;
  localparam int ISQRT_R_W = 18;

  typedef struct packed {
    logic                 vld;
    logic [ISQRT_X_W-1:0] x_rem;
    logic [ISQRT_R_W-1:0] rem;
    logic [ISQRT_Y_W-1:0] root;
  } isqrt_stage_t;

endpackage

// File: rtl/isqrt_step.sv
// One digit-recurrence iteration: brings in two radicand bits and decides one root bit.
module isqrt_step
  import isqrt_pkg::*;
(
  input  logic [ISQRT_R_W-1:0] rem,
  input  logic [ISQRT_Y_W-1:0] root,
  input  logic [1:0]           bits,
  output logic [ISQRT_R_W-1:0] rem_next,
  output logic [ISQRT_Y_W-1:0] root_next
);

  logic [ISQRT_R_W-1:0] rem_sh;
  logic [ISQRT_R_W-1:0] trial;
  logic                 ge;

  // The partial remainder never exceeds 2*root, so the shifted value fits in 18 bits.
  always_comb begin
    rem_sh    = {rem[ISQRT_R_W-3:0], bits};
    trial     = {root, 2'b01};
    ge        = (rem_sh >= trial);
    rem_next  = ge ? (rem_sh - trial) : rem_sh;
    root_next = {root[ISQRT_Y_W-2:0], ge};
  end

endmodule

// File: rtl/isqrt_pipe.sv
// Pipelined floor(sqrt(x)) for 32-bit radicands; one result per clock, fixed latency N_STAGES.
// Only the valid bits matter during reset; data fields simply follow them down the pipe.
module isqrt_pipe
  import isqrt_pkg::*;
#(
  parameter int N_STAGES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 x_vld,
  input  logic [ISQRT_X_W-1:0] x,
  output logic                 y_vld,
  output logic [ISQRT_Y_W-1:0] y
);

  localparam int STEPS = ISQRT_Y_W / N_STAGES;

  if (!(N_STAGES inside {1, 2, 4, 8, 16})) begin : g_bad_param
    $error("isqrt_pipe: N_STAGES must be one of 1, 2, 4, 8, 16");
  end

  for (genvar s = 0; s < N_STAGES; s++) begin : g_stage
    isqrt_stage_t         src;
    isqrt_stage_t         stage_q;
    logic [ISQRT_R_W-1:0] rem_c  [STEPS+1];
    logic [ISQRT_Y_W-1:0] root_c [STEPS+1];
    logic [ISQRT_X_W-1:0] xr_c   [STEPS+1];

    if (s == 0) begin : g_src_in
      assign src = {x_vld, x, ISQRT_R_W'(0), ISQRT_Y_W'(0)};
    end else begin : g_src_prev
      assign src = g_stage[s-1].stage_q;
    end

    assign rem_c[0]  = src.rem;
    assign root_c[0] = src.root;
    assign xr_c[0]   = src.x_rem;

    // Radicand bits are consumed from the top, two per iteration.
    for (genvar k = 0; k < STEPS; k++) begin : g_step
      isqrt_step u_step (
        .rem       (rem_c[k]),
        .root      (root_c[k]),
        .bits      (xr_c[k][ISQRT_X_W-1:ISQRT_X_W-2]),
        .rem_next  (rem_c[k+1]),
        .root_next (root_c[k+1])
      );
      assign xr_c[k+1] = {xr_c[k][ISQRT_X_W-3:0], 2'b00};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_q <= '0;
      end else begin
        stage_q <= {src.vld, xr_c[STEPS], rem_c[STEPS], root_c[STEPS]};
      end
    end
  end

  assign y_vld = g_stage[N_STAGES-1].stage_q.vld;
  assign y     = g_stage[N_STAGES-1].stage_q.root;

endmodule

// File: tb/tb_isqrt_pipe.sv
// Self-checking bench: three isqrt_pipe instances (N_STAGES = 16, 4, 1) share one stimulus
// stream and are checked cycle by cycle against a plain-arithmetic square-root model.
module tb_isqrt_pipe;

  localparam int MAXC = 10100;
  localparam int TAIL = 18;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        x_vld = 1'b0;
  logic [31:0] x     = '0;
  logic        vld16, vld4, vld1;
  logic [15:0] y16, y4, y1;

  int checks = 0;
  int fails  = 0;
  int lat [3] = '{16, 4, 1};

  logic        in_vld [MAXC];
  logic [31:0] in_x   [MAXC];
  logic [15:0] in_exp [MAXC];
  logic        o_vld  [3][MAXC];
  logic [15:0] o_y    [3][MAXC];
  int n_in  = 0;
  int n_cyc = 0;

  always #5 clk = ~clk;

  isqrt_pipe #(.N_STAGES(16)) dut16 (.clk(clk), .rst_n(rst_n), .x_vld(x_vld), .x(x), .y_vld(vld16), .y(y16));
  isqrt_pipe #(.N_STAGES(4))  dut4  (.clk(clk), .rst_n(rst_n), .x_vld(x_vld), .x(x), .y_vld(vld4),  .y(y4));
  isqrt_pipe #(.N_STAGES(1))  dut1  (.clk(clk), .rst_n(rst_n), .x_vld(x_vld), .x(x), .y_vld(vld1),  .y(y1));

  // Reference: floating-point estimate corrected to the exact integer floor.
  function automatic logic [15:0] ref_sqrt(input logic [31:0] v);
    longint r;
    r = longint'($floor($sqrt(real'(v))));
    while (r * r > longint'(v)) r--;
    while ((r + 1) * (r + 1) <= longint'(v)) r++;
    return r[15:0];
  endfunction

  // Index of the input whose result is due at cycle c on DUT d, or -1 when none is due.
  function automatic int src_idx(input int d, input int c);
    int j;
    j = c - (lat[d] - 1);
    if (j < 0 || j >= n_in) return -1;
    return in_vld[j] ? j : -1;
  endfunction

  task automatic run_seq(input int n);
    n_in  = n;
    n_cyc = n + TAIL;
    for (int c = 0; c < n_cyc; c++) begin
      x_vld = (c < n) ? in_vld[c] : 1'b0;
      x     = (c < n) ? in_x[c] : $urandom;
      @(posedge clk);
      #1;
      o_vld[0][c] = vld16; o_y[0][c] = y16;
      o_vld[1][c] = vld4;  o_y[1][c] = y4;
      o_vld[2][c] = vld1;  o_y[2][c] = y1;
    end
    x_vld = 1'b0;
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({vld16, vld4, vld1} !== 3'b000) begin
      fails++;
      $display("[TB] FAIL reset_async y_vld: got %b expected 000", {vld16, vld4, vld1});
    end
    x_vld = 1'b1;
    x     = 32'd49;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({vld16, vld4, vld1} !== 3'b000) begin
      fails++;
      $display("[TB] FAIL reset_held y_vld: got %b expected 000", {vld16, vld4, vld1});
    end
    x_vld = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic test_corners;
    logic [31:0] cx [8] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd15, 32'd16, 32'hFFFF_FFFF};
    logic [15:0] cy [8] = '{16'd0, 16'd1, 16'd1, 16'd1, 16'd2, 16'd3, 16'd4, 16'hFFFF};
    for (int t = 0; t < 8; t++) begin
      in_vld[0] = 1'b1;
      in_x[0]   = cx[t];
      in_exp[0] = cy[t];
      run_seq(1);
      for (int d = 0; d < 3; d++) begin
        for (int c = 0; c < n_cyc; c++) begin
          int j;
          j = src_idx(d, c);
          checks++;
          if (o_vld[d][c] !== 1'(j >= 0)) begin
            fails++;
            $display("[TB] FAIL corner x=%0h y_vld N=%0d cycle %0d: got %b expected %b", cx[t], lat[d], c, o_vld[d][c], j >= 0);
          end else if (j >= 0) begin
            checks++;
            if (o_y[d][c] !== in_exp[j]) begin
              fails++;
              $display("[TB] FAIL corner x=%0h y N=%0d: got %0d expected %0d", cx[t], lat[d], o_y[d][c], in_exp[j]);
            end
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 64; i++) begin
      int     kind;
      longint iv;
      kind = i % 3;
      iv   = longint'($urandom_range(65535));
      if (kind == 1 && iv == 0) iv = 1;
      in_vld[i] = 1'b1;
      case (kind)
        0:       begin in_x[i] = 32'(iv * iv);     in_exp[i] = 16'(iv);     end
        1:       begin in_x[i] = 32'(iv * iv - 1); in_exp[i] = 16'(iv - 1); end
        default: begin in_x[i] = 32'(iv * iv + 1); in_exp[i] = 16'(iv);     end
      endcase
    end
    run_seq(64);
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < n_cyc; c++) begin
        int j;
        j = src_idx(d, c);
        checks++;
        if (o_vld[d][c] !== 1'(j >= 0)) begin
          fails++;
          $display("[TB] FAIL stream y_vld N=%0d cycle %0d: got %b expected %b", lat[d], c, o_vld[d][c], j >= 0);
        end else if (j >= 0) begin
          checks++;
          if (o_y[d][c] !== in_exp[j]) begin
            fails++;
            $display("[TB] FAIL stream y N=%0d item %0d x=%0h: got %0d expected %0d", lat[d], j, in_x[j], o_y[d][c], in_exp[j]);
          end
        end
      end
    end
  endtask

  task automatic test_bubbles;
    logic pat [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      in_vld[i] = pat[i];
      in_x[i]   = $urandom;
      in_exp[i] = ref_sqrt(in_x[i]);
    end
    run_seq(7);
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < n_cyc; c++) begin
        int j;
        j = src_idx(d, c);
        checks++;
        if (o_vld[d][c] !== 1'(j >= 0)) begin
          fails++;
          $display("[TB] FAIL bubble y_vld N=%0d cycle %0d: got %b expected %b", lat[d], c, o_vld[d][c], j >= 0);
        end else if (j >= 0) begin
          checks++;
          if (o_y[d][c] !== in_exp[j]) begin
            fails++;
            $display("[TB] FAIL bubble y N=%0d item %0d: got %0d expected %0d", lat[d], j, o_y[d][c], in_exp[j]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_midflight;
    for (int c = 0; c < 5; c++) begin
      x_vld = 1'b1;
      x     = $urandom;
      @(posedge clk);
      #1;
    end
    x_vld = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({vld16, vld4, vld1} !== 3'b000) begin
      fails++;
      $display("[TB] FAIL midflight_drop y_vld: got %b expected 000", {vld16, vld4, vld1});
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({vld16, vld4, vld1} !== 3'b000) begin
        fails++;
        $display("[TB] FAIL midflight_stale cycle %0d y_vld: got %b expected 000", c, {vld16, vld4, vld1});
      end
    end
    in_vld[0] = 1'b1;
    in_x[0]   = 32'd100;
    in_exp[0] = 16'd10;
    run_seq(1);
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < n_cyc; c++) begin
        int j;
        j = src_idx(d, c);
        checks++;
        if (o_vld[d][c] !== 1'(j >= 0)) begin
          fails++;
          $display("[TB] FAIL post_reset y_vld N=%0d cycle %0d: got %b expected %b", lat[d], c, o_vld[d][c], j >= 0);
        end else if (j >= 0) begin
          checks++;
          if (o_y[d][c] !== in_exp[j]) begin
            fails++;
            $display("[TB] FAIL post_reset y N=%0d: got %0d expected %0d", lat[d], o_y[d][c], in_exp[j]);
          end
        end
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 10000; i++) begin
      in_vld[i] = ($urandom_range(7) != 0);
      case ($urandom_range(3))
        0:       in_x[i] = $urandom_range(1023);
        1:       in_x[i] = 32'hFFFF_0000 | $urandom_range(65535);
        default: in_x[i] = $urandom;
      endcase
      in_exp[i] = ref_sqrt(in_x[i]);
    end
    run_seq(10000);
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < n_cyc; c++) begin
        int j;
        j = src_idx(d, c);
        checks++;
        if (o_vld[d][c] !== 1'(j >= 0)) begin
          fails++;
          $display("[TB] FAIL random y_vld N=%0d cycle %0d: got %b expected %b", lat[d], c, o_vld[d][c], j >= 0);
        end else if (j >= 0) begin
          checks++;
          if (o_y[d][c] !== in_exp[j]) begin
            fails++;
            $display("[TB] FAIL random y N=%0d x=%0h: got %0d expected %0d", lat[d], in_x[j], o_y[d][c], in_exp[j]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_corners();
    test_back_to_back();
    test_bubbles();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
